// File: rtl/gpx2_echo_collector.sv
// gpx2_echo_collector: pairs GPX2 rise/fall stop words with the latest start word and emits per-echo times
// Ports: i_clk_100m/i_rst clock and async reset; i_module_en/i_measure_sign enable and abort;
// i_start_*/i_rise_*/i_fall_* GPX2 result strobes and words; i_out_ready downstream accept;
// o_echo_valid/o_echo_idx/o_rise_time/o_fall_time/o_pulse_width echo result held until accepted;
// o_frame_done/o_echo_cnt frame close pulse and delivered echo count; o_sync_ready waiting for a start.
module gpx2_echo_collector #(
  parameter int DATA_W      = 32,
  parameter int NUM_ECHO    = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              i_clk_100m,
  input  logic              i_rst,
  input  logic              i_module_en,
  input  logic              i_measure_sign,
  input  logic              i_start_valid,
  input  logic [DATA_W-1:0] i_start_data,
  input  logic              i_rise_valid,
  input  logic [DATA_W-1:0] i_rise_data,
  input  logic              i_fall_valid,
  input  logic [DATA_W-1:0] i_fall_data,
  input  logic              i_out_ready,
  output logic              o_echo_valid,
  output logic [1:0]        o_echo_idx,
  output logic [DATA_W-1:0] o_rise_time,
  output logic [DATA_W-1:0] o_fall_time,
  output logic [DATA_W-1:0] o_pulse_width,
  output logic              o_frame_done,
  output logic [2:0]        o_echo_cnt,
  output logic              o_sync_ready
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, WAIT_START, WAIT_RISE, WAIT_FALL, CALC, OUT, DONE} state_t;
  state_t state, nxt;
  logic [DATA_W-1:0] start_word, rise_word, fall_word;
  logic [TW-1:0] tmo;
  logic [2:0] cnt;
  logic pend, abort, waiting, stop_hit, tmo_hit, last;
  assign abort    = !i_module_en || i_measure_sign;
  assign waiting  = state == WAIT_RISE || state == WAIT_FALL;
  assign stop_hit = (state == WAIT_RISE && i_rise_valid) || (state == WAIT_FALL && (i_rise_valid || i_fall_valid));
  assign tmo_hit  = tmo == TW'(TIMEOUT_CYC - 1);
  assign last     = cnt + 3'd1 == 3'(NUM_ECHO);
  assign o_echo_valid = state == OUT;
  assign o_frame_done = state == DONE;
  assign o_sync_ready = state == WAIT_START;
  assign o_echo_cnt   = cnt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = WAIT_START;
      WAIT_START: nxt = i_start_valid ? WAIT_RISE : WAIT_START;
      WAIT_RISE:  nxt = i_start_valid ? DONE : i_rise_valid ? (i_fall_valid ? CALC : WAIT_FALL) : tmo_hit ? DONE : WAIT_RISE;
      WAIT_FALL:  nxt = i_start_valid ? DONE : i_fall_valid ? CALC : (!i_rise_valid && tmo_hit) ? DONE : WAIT_FALL;
      CALC:       nxt = OUT;
      OUT:        nxt = !i_out_ready ? OUT : last ? DONE : WAIT_RISE;
      DONE:       nxt = pend ? WAIT_RISE : WAIT_START;
      default:    nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge i_clk_100m or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge i_clk_100m or posedge i_rst)
    if (i_rst) begin
      {start_word, rise_word, fall_word, tmo, cnt, pend} <= '0;
      {o_rise_time, o_fall_time, o_pulse_width, o_echo_idx} <= '0;
    end else if (abort) begin
      {start_word, rise_word, fall_word, tmo, cnt, pend} <= '0;
      {o_rise_time, o_fall_time, o_pulse_width, o_echo_idx} <= '0;
    end else begin
      tmo  <= waiting && !stop_hit ? tmo + 1'b1 : '0;
      // a start inside a frame closes it; the flag steers DONE straight back to WAIT_RISE
      pend <= waiting && i_start_valid;
      if (i_start_valid && (state == WAIT_START || waiting)) start_word <= i_start_data;
      if ((state == WAIT_START && i_start_valid) || (state == DONE && pend)) cnt <= '0;
      else if (state == OUT && i_out_ready) cnt <= cnt + 3'd1;
      if (!i_start_valid && state == WAIT_RISE && i_rise_valid) begin
        rise_word <= i_rise_data;
        if (i_fall_valid) fall_word <= i_fall_data;
      end
      if (!i_start_valid && state == WAIT_FALL) begin
        if (i_fall_valid) fall_word <= i_fall_data;
        else if (i_rise_valid) rise_word <= i_rise_data;
      end
      if (state == CALC) begin
        o_rise_time   <= rise_word - start_word;
        o_fall_time   <= fall_word - start_word;
        o_pulse_width <= fall_word - rise_word;
        o_echo_idx    <= cnt[1:0];
      end
    end
endmodule

// File: doc/gpx2_echo_collector.md
GPX2_ECHO_COLLECTOR -- requirements
Module: gpx2_echo_collector

Interface
REQ-001 Parameter DATA_W, default 32, width of GPX2 result words and of all computed times.
REQ-002 Parameter NUM_ECHO, default 2, legal range 1..4, maximum rise/fall echo pairs collected per start.
REQ-003 Parameter TIMEOUT_CYC, default 1000, number of i_clk_100m cycles without a stop word before the frame is closed.
REQ-004 i_clk_100m  input  1  sole clock; all logic on its rising edge.
REQ-005 i_rst  input  1  asynchronous, active-high reset.
REQ-006 i_module_en  input  1  block enable; low forces IDLE.
REQ-007 i_measure_sign  input  1  synchronous abort/angle sync; high forces IDLE.
REQ-008 i_start_valid, i_start_data  input  1, DATA_W  main-wave (start) result word strobe and value.
REQ-009 i_rise_valid, i_rise_data  input  1, DATA_W  echo front-edge stop word strobe and value.
REQ-010 i_fall_valid, i_fall_data  input  1, DATA_W  echo final-edge stop word strobe and value.
REQ-011 i_out_ready  input  1  downstream accepts the presented echo.
REQ-012 o_echo_valid  output  1  echo result presented; held until accepted.
REQ-013 o_echo_idx  output  2  echo number within frame, 0-based.
REQ-014 o_rise_time, o_fall_time, o_pulse_width  output  DATA_W each  rise-start, fall-start, fall-rise.
REQ-015 o_frame_done  output  1  one-cycle pulse when a frame closes.
REQ-016 o_echo_cnt  output  3  echoes delivered in the closed frame; valid with o_frame_done.
REQ-017 o_sync_ready  output  1  high only in WAIT_START.

Function
REQ-018 States: IDLE, WAIT_START, WAIT_RISE, WAIT_FALL, CALC, OUT, DONE.
REQ-019 IDLE -> WAIT_START when i_module_en high and i_measure_sign low; i_module_en low or i_measure_sign high SHALL force IDLE from any state next cycle, discarding stored data, no o_frame_done.
REQ-020 WAIT_START: on i_start_valid latch start word, clear echo count and timeout counter, -> WAIT_RISE.
REQ-021 WAIT_RISE: on i_rise_valid latch rise word, -> WAIT_FALL; i_fall_valid here SHALL be ignored.
REQ-022 WAIT_FALL: on i_fall_valid latch fall word, -> CALC; a further i_rise_valid SHALL overwrite the stored rise word.
REQ-023 Simultaneous i_rise_valid and i_fall_valid in WAIT_RISE: latch both, -> CALC.
REQ-024 CALC (1 cycle): rise-start, fall-start, fall-rise computed modulo 2^DATA_W (unsigned wrap, no saturation), registered into outputs, -> OUT.
REQ-025 OUT: o_echo_valid high with stable data; on i_out_ready high, increment echo count; -> DONE if count reaches NUM_ECHO, else WAIT_RISE with timeout counter cleared.
REQ-026 Timeout counter increments each cycle in WAIT_RISE/WAIT_FALL, clears on any accepted stop word; at TIMEOUT_CYC -> DONE, pending unpaired rise dropped.
REQ-027 i_start_valid during WAIT_RISE/WAIT_FALL closes the frame: -> DONE, new start word latched for the next frame, which begins in WAIT_RISE directly.
REQ-028 DONE (1 cycle): o_frame_done pulse with o_echo_cnt; -> WAIT_START, or WAIT_RISE if a start was latched per REQ-027.
REQ-029 Stop words arriving in CALC, OUT, DONE SHALL be dropped.
REQ-030 Latency: fall strobe to o_echo_valid = 2 cycles.

Reset
REQ-031 i_rst high SHALL asynchronously force IDLE and clear all outputs, counters and stored words to 0; reset mid-frame SHALL produce no o_frame_done.
REQ-032 First state change after reset release requires one clock edge with i_module_en high.

Verification
REQ-033 start=0x100, rise=0x180, fall=0x1C0, ready high -> o_rise_time=0x80, o_fall_time=0xC0, o_pulse_width=0x40, idx 0, 2 cycles after fall.
REQ-034 start=0xFFFF_FFF0, rise=0x10, fall=0x30 -> rise 0x20, fall 0x40, width 0x20 (wrap).
REQ-035 NUM_ECHO=2, two echo pairs, i_out_ready low 5 cycles on first -> data held stable, then idx 0,1 delivered, o_frame_done with o_echo_cnt=2.
REQ-036 start, rise only, no fall for TIMEOUT_CYC -> no o_echo_valid, o_frame_done with o_echo_cnt=0.
REQ-037 i_measure_sign pulse in WAIT_FALL -> IDLE, no frame_done; fall before rise -> ignored; new start mid-frame -> frame_done, next echo referenced to new start.
